// File: rtl/sht40_measure_ctrl.sv
// sht40_measure_ctrl
// Sequences one SHT40 measurement through an external I2C master:
// command write, conversion wait, 6-byte read, CRC-8 check of both words,
// and publication of the raw temperature and humidity words.
// A watchdog bounds every state that waits on the master.

module sht40_measure_ctrl #(
    parameter logic [6:0]  SHT_ADDR         = 7'h44,
    parameter logic [7:0]  CMD              = 8'hFD,
    parameter int unsigned MEAS_WAIT_CYCLES = 20000,
    parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        Processor_Ready,
    output logic [6:0]  Peripheral_Address,
    output logic        r_or_w,
    output logic        i2c_writes,
    output logic [7:0]  Tx_Byte,
    output logic [3:0]  SHT_Reads,
    output logic        CRC_Error,
    input  logic [7:0]  Data_Received,
    input  logic [3:0]  Output_Received_Counter,
    input  logic        master_done,
    output logic [15:0] temp_raw,
    output logic [15:0] rh_raw,
    output logic        data_valid,
    output logic        crc_err,
    output logic        timeout
);

    localparam int MW = (MEAS_WAIT_CYCLES > 1) ? $clog2(MEAS_WAIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR_REQ     = 4'd1;
    localparam logic [3:0] S_WR_WAIT    = 4'd2;
    localparam logic [3:0] S_MEAS_WAIT  = 4'd3;
    localparam logic [3:0] S_RD_REQ     = 4'd4;
    localparam logic [3:0] S_RD_COLLECT = 4'd5;
    localparam logic [3:0] S_RD_END     = 4'd6;
    localparam logic [3:0] S_RESULT     = 4'd7;
    localparam logic [3:0] S_ABORT      = 4'd8;

    // Sensirion CRC-8 over one byte: poly 0x31, MSB first, unrolled 8 steps
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [2:0]    r_idx;
    logic [15:0]   r_temp_buf;
    logic [15:0]   r_rh_buf;
    logic [7:0]    r_crc;
    logic [3:0]    r_prev_cnt;
    logic [MW-1:0] r_meas_cnt;
    logic [TW-1:0] r_wd_cnt;
    logic          r_busy;
    logic          r_proc_ready;
    logic          r_r_or_w;
    logic          r_crc_error;
    logic [15:0]   r_temp;
    logic [15:0]   r_rh;
    logic          r_data_valid;
    logic          r_crc_err;
    logic          r_timeout;

    logic          w_accept;
    logic          w_strobe;
    logic          w_crc_fail;
    logic          w_wd_run;
    logic          w_wd_zero;
    logic          w_set_to;
    logic          w_abort;

    assign w_accept   = (r_state == S_IDLE) && start;
    // Inequality only: a 15->0 wrap of the master's counter is still a new byte
    assign w_strobe   = (r_state == S_RD_COLLECT) && (Output_Received_Counter != r_prev_cnt);
    assign w_crc_fail = w_strobe && ((r_idx == 3'd2) || (r_idx == 3'd5)) && (Data_Received != r_crc);
    assign w_wd_run   = (r_state == S_WR_WAIT) || (r_state == S_RD_COLLECT) ||
                        (r_state == S_RD_END)  || (r_state == S_ABORT);
    assign w_wd_zero  = (r_wd_cnt == '0);

    // Next-state decode, plus the timeout and CRC-abort events it implies
    always_comb begin
        w_next   = r_state;
        w_set_to = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WR_REQ;
                else       w_next = S_IDLE;
            end
            S_WR_REQ: w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (master_done) begin
                    w_next = S_MEAS_WAIT;
                end else if (w_wd_zero) begin
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end else begin
                    w_next = S_WR_WAIT;
                end
            end
            S_MEAS_WAIT: begin
                if (r_meas_cnt == '0) w_next = S_RD_REQ;
                else                  w_next = S_MEAS_WAIT;
            end
            S_RD_REQ: w_next = S_RD_COLLECT;
            S_RD_COLLECT: begin
                if (master_done) begin
                    // master finished before all six bytes arrived
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end else if (w_crc_fail) begin
                    w_next  = S_ABORT;
                    w_abort = 1'b1;
                end else if (w_strobe && (r_idx == 3'd5)) begin
                    w_next = S_RD_END;
                end else if (w_strobe) begin
                    w_next = S_RD_COLLECT;
                end else if (w_wd_zero) begin
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end else begin
                    w_next = S_RD_COLLECT;
                end
            end
            S_RD_END: begin
                if (master_done) begin
                    w_next = S_RESULT;
                end else if (w_wd_zero) begin
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end else begin
                    w_next = S_RD_END;
                end
            end
            S_RESULT: w_next = S_IDLE;
            S_ABORT: begin
                if (master_done) begin
                    w_next = S_IDLE;
                end else if (w_wd_zero) begin
                    w_next   = S_IDLE;
                    w_set_to = 1'b1;
                end else begin
                    w_next = S_ABORT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and registered control outputs/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_proc_ready <= 1'b0;
            r_r_or_w     <= 1'b0;
            r_crc_error  <= 1'b0;
            r_data_valid <= 1'b0;
            r_crc_err    <= 1'b0;
            r_timeout    <= 1'b0;
            r_temp       <= 16'h0000;
            r_rh         <= 16'h0000;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_proc_ready <= (w_next == S_WR_REQ) || (w_next == S_RD_REQ);
            r_crc_error  <= w_abort;
            r_data_valid <= (w_next == S_RESULT);
            if (w_next == S_WR_REQ)      r_r_or_w <= 1'b0;
            else if (w_next == S_RD_REQ) r_r_or_w <= 1'b1;
            else                         r_r_or_w <= r_r_or_w;
            if (w_accept) begin
                r_crc_err <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                r_crc_err <= r_crc_err | w_abort;
                r_timeout <= r_timeout | w_set_to;
            end
            if (w_next == S_RESULT) begin
                r_temp <= r_temp_buf;
                r_rh   <= r_rh_buf;
            end else begin
                r_temp <= r_temp;
                r_rh   <= r_rh;
            end
        end
    end

    // Byte collection: index, word shift buffers, running CRC, last counter seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 3'd0;
            r_temp_buf <= 16'h0000;
            r_rh_buf   <= 16'h0000;
            r_crc      <= 8'h00;
            r_prev_cnt <= 4'd0;
        end else if (w_accept) begin
            r_idx      <= 3'd0;
            r_temp_buf <= 16'h0000;
            r_rh_buf   <= 16'h0000;
            r_crc      <= 8'h00;
            r_prev_cnt <= r_prev_cnt;
        end else if (r_state == S_RD_REQ) begin
            r_prev_cnt <= Output_Received_Counter;
        end else if (w_strobe) begin
            r_prev_cnt <= Output_Received_Counter;
            r_idx      <= r_idx + 3'd1;
            // bytes 0/3 restart the CRC, bytes 1/4 extend it, 2/5 are checked
            if ((r_idx == 3'd0) || (r_idx == 3'd3)) r_crc <= crc8_byte(8'hFF, Data_Received);
            else                                    r_crc <= crc8_byte(r_crc, Data_Received);
            if (r_idx < 3'd2)                           r_temp_buf <= {r_temp_buf[7:0], Data_Received};
            else if ((r_idx == 3'd3) || (r_idx == 3'd4)) r_rh_buf  <= {r_rh_buf[7:0], Data_Received};
            else                                         r_rh_buf  <= r_rh_buf;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Conversion delay counter and master watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas_cnt <= '0;
            r_wd_cnt   <= '0;
        end else begin
            if ((r_state == S_WR_WAIT) && (w_next == S_MEAS_WAIT))
                r_meas_cnt <= MW'(MEAS_WAIT_CYCLES - 1);
            else if ((r_state == S_MEAS_WAIT) && (r_meas_cnt != '0))
                r_meas_cnt <= r_meas_cnt - MW'(1);
            else
                r_meas_cnt <= r_meas_cnt;
            // a strobe reloads even when the count has just run out
            if ((w_next != r_state) || w_strobe)
                r_wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
            else if (w_wd_run && !w_wd_zero)
                r_wd_cnt <= r_wd_cnt - TW'(1);
            else
                r_wd_cnt <= r_wd_cnt;
        end
    end

    assign busy               = r_busy;
    assign Processor_Ready    = r_proc_ready;
    assign Peripheral_Address = SHT_ADDR;
    assign r_or_w             = r_r_or_w;
    assign i2c_writes         = 1'b1;
    assign Tx_Byte            = CMD;
    assign SHT_Reads          = 4'd5;
    assign CRC_Error          = r_crc_error;
    assign temp_raw           = r_temp;
    assign rh_raw             = r_rh;
    assign data_valid         = r_data_valid;
    assign crc_err            = r_crc_err;
    assign timeout            = r_timeout;

endmodule

// File: tb/tb_sht40_measure_ctrl.sv
// Directed testbench for sht40_measure_ctrl with a scripted I2C master.
// Built with MEAS_WAIT_CYCLES=10 and TIMEOUT_CYCLES=50.

module tb_sht40_measure_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        master_done;
    logic [7:0]  Data_Received;
    logic [3:0]  ord_cnt;
    logic        busy;
    logic        Processor_Ready;
    logic [6:0]  Peripheral_Address;
    logic        r_or_w;
    logic        i2c_writes;
    logic [7:0]  Tx_Byte;
    logic [3:0]  SHT_Reads;
    logic        CRC_Error;
    logic [15:0] temp_raw;
    logic [15:0] rh_raw;
    logic        data_valid;
    logic        crc_err;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_count = 0;
    int pr_count = 0;
    int n_double = 0;
    logic pr_prev = 1'b0;

    always #5 clk = ~clk;

    sht40_measure_ctrl #(
        .SHT_ADDR(7'h44), .CMD(8'hFD), .MEAS_WAIT_CYCLES(10), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .Processor_Ready(Processor_Ready), .Peripheral_Address(Peripheral_Address),
        .r_or_w(r_or_w), .i2c_writes(i2c_writes), .Tx_Byte(Tx_Byte), .SHT_Reads(SHT_Reads),
        .CRC_Error(CRC_Error), .Data_Received(Data_Received),
        .Output_Received_Counter(ord_cnt), .master_done(master_done),
        .temp_raw(temp_raw), .rh_raw(rh_raw), .data_valid(data_valid),
        .crc_err(crc_err), .timeout(timeout)
    );

    // Mid-cycle pulse counters for data_valid and Processor_Ready
    always @(negedge clk) begin
        if (data_valid) dv_count <= dv_count + 1;
        if (Processor_Ready) pr_count <= pr_count + 1;
        if (Processor_Ready && pr_prev) n_double <= n_double + 1;
        pr_prev <= Processor_Ready;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the WR_REQ cycle: master acks the write; returns cycles from the
    // master_done cycle to the read request (bounded)
    task automatic write_phase(output int lat);
        tick();
        tick();
        tick();
        master_done = 1'b1;
        tick();
        master_done = 1'b0;
        lat = 1;
        while (Processor_Ready !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ord_cnt       = ord_cnt + 4'd1;
        Data_Received = b;
        tick();
    endtask

    task automatic finish_read();
        tick();
        master_done = 1'b1;
        tick();
        master_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; master_done = 1'b0;
        Data_Received = 8'h00; ord_cnt = 4'd0;
        #12;
        n_checks++;
        if ({busy, Processor_Ready, r_or_w, CRC_Error, data_valid, crc_err, timeout} !== 7'b0) begin
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, Processor_Ready, r_or_w, CRC_Error, data_valid, crc_err, timeout});
            n_fail++;
        end
        n_checks++;
        if ({temp_raw, rh_raw} !== 32'h0) begin
            $display("FAIL reset_words: got %h required 00000000", {temp_raw, rh_raw});
            n_fail++;
        end
        n_checks++;
        if ({Peripheral_Address, Tx_Byte, i2c_writes, SHT_Reads} !== {7'h44, 8'hFD, 1'b1, 4'd5}) begin
            $display("FAIL reset_consts: got %h %h %b %h required 44 fd 1 5",
                     Peripheral_Address, Tx_Byte, i2c_writes, SHT_Reads);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int lat;
        int dv0;
        dv0 = dv_count;
        ord_cnt = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({Processor_Ready, r_or_w, busy} !== 3'b101) begin
            $display("FAIL nom_write_req: got %b required 101", {Processor_Ready, r_or_w, busy});
            n_fail++;
        end
        write_phase(lat);
        n_checks++;
        if (lat != 11) begin
            $display("FAIL nom_meas_delay: got %0d cycles required 11", lat);
            n_fail++;
        end
        n_checks++;
        if (r_or_w !== 1'b1) begin
            $display("FAIL nom_read_dir: got %b required 1", r_or_w);
            n_fail++;
        end
        tick();
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
        send_byte(8'h66); send_byte(8'h66); send_byte(8'h93);
        finish_read();
        n_checks++;
        if ({data_valid, crc_err, temp_raw, rh_raw} !== {1'b1, 1'b0, 16'hBEEF, 16'h6666}) begin
            $display("FAIL nom_result: got dv=%b crc_err=%b temp=%h rh=%h required dv=1 crc_err=0 temp=beef rh=6666",
                     data_valid, crc_err, temp_raw, rh_raw);
            n_fail++;
        end
        tick();
        n_checks++;
        if ({busy, data_valid} !== 2'b00 || (dv_count - dv0) != 1) begin
            $display("FAIL nom_idle: got busy=%b dv=%b pulses=%0d required busy=0 dv=0 pulses=1",
                     busy, data_valid, dv_count - dv0);
            n_fail++;
        end
    endtask

    task automatic test_bad_crc();
        int lat;
        int dv0;
        dv0 = dv_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        write_phase(lat);
        tick();
        send_byte(8'hBE);
        send_byte(8'hEF);
        n_checks++;
        if (CRC_Error !== 1'b0) begin
            $display("FAIL bad_early_abort: got %b required 0", CRC_Error);
            n_fail++;
        end
        send_byte(8'h93);
        n_checks++;
        if ({CRC_Error, crc_err, busy} !== 3'b111) begin
            $display("FAIL bad_abort_pulse: got %b required 111", {CRC_Error, crc_err, busy});
            n_fail++;
        end
        tick();
        n_checks++;
        if ({CRC_Error, busy} !== 2'b01) begin
            $display("FAIL bad_pulse_width: got %b required 01", {CRC_Error, busy});
            n_fail++;
        end
        master_done = 1'b1;
        tick();
        master_done = 1'b0;
        n_checks++;
        if ({busy, crc_err} !== 2'b01 || {temp_raw, rh_raw} !== {16'hBEEF, 16'h6666} || dv_count != dv0) begin
            $display("FAIL bad_end: got busy=%b crc_err=%b words=%h pulses=%0d required busy=0 crc_err=1 words=beef6666 pulses=0",
                     busy, crc_err, {temp_raw, rh_raw}, dv_count - dv0);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (49) tick();
        n_checks++;
        if ({busy, timeout} !== 2'b10) begin
            $display("FAIL to_before: got %b required 10", {busy, timeout});
            n_fail++;
        end
        tick();
        n_checks++;
        if ({busy, timeout} !== 2'b01) begin
            $display("FAIL to_expire: got %b required 01", {busy, timeout});
            n_fail++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, timeout, crc_err} !== 3'b100) begin
            $display("FAIL to_clear: got %b required 100", {busy, timeout, crc_err});
            n_fail++;
        end
        repeat (51) tick();
        n_checks++;
        if ({busy, timeout} !== 2'b01) begin
            $display("FAIL to_again: got %b required 01", {busy, timeout});
            n_fail++;
        end
    endtask

    task automatic test_start_held();
        int lat;
        int pr0;
        pr0 = pr_count;
        start = 1'b1;
        tick();
        n_checks++;
        if ({Processor_Ready, timeout} !== 2'b10) begin
            $display("FAIL held_first_req: got %b required 10", {Processor_Ready, timeout});
            n_fail++;
        end
        write_phase(lat);
        n_checks++;
        if (lat != 11) begin
            $display("FAIL held_meas_delay: got %0d cycles required 11", lat);
            n_fail++;
        end
        tick();
        send_byte(8'h66); send_byte(8'h66); send_byte(8'h93);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
        finish_read();
        n_checks++;
        if ({data_valid, temp_raw, rh_raw} !== {1'b1, 16'h6666, 16'hBEEF}) begin
            $display("FAIL held_result: got dv=%b temp=%h rh=%h required dv=1 temp=6666 rh=beef",
                     data_valid, temp_raw, rh_raw);
            n_fail++;
        end
        tick();
        n_checks++;
        if ({busy, Processor_Ready} !== 2'b00) begin
            $display("FAIL held_idle_visit: got %b required 00", {busy, Processor_Ready});
            n_fail++;
        end
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, Processor_Ready, r_or_w} !== 3'b110) begin
            $display("FAIL held_restart: got %b required 110", {busy, Processor_Ready, r_or_w});
            n_fail++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ((pr_count - pr0) != 3 || n_double != 0) begin
            $display("FAIL held_ready_pulses: got %0d pulses %0d doubles required 3 pulses 0 doubles",
                     pr_count - pr0, n_double);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        int lat;
        write_phase(lat);
        tick();
        send_byte(8'h00);
        send_byte(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, Processor_Ready, r_or_w, timeout, crc_err} !== 5'b0 || {temp_raw, rh_raw} !== 32'h0) begin
            $display("FAIL async_reset: got flags=%b words=%h required flags=00000 words=00000000",
                     {busy, Processor_Ready, r_or_w, timeout, crc_err}, {temp_raw, rh_raw});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, Processor_Ready} !== 2'b11) begin
            $display("FAIL async_restart: got %b required 11", {busy, Processor_Ready});
            n_fail++;
        end
    endtask

    // Continues the post-reset measurement; a byte lands on the expiry cycle
    task automatic test_strobe_vs_watchdog();
        int lat;
        write_phase(lat);
        n_checks++;
        if (lat != 11) begin
            $display("FAIL sw_meas_delay: got %0d cycles required 11", lat);
            n_fail++;
        end
        tick();
        repeat (49) tick();
        send_byte(8'h00);
        n_checks++;
        if ({busy, timeout} !== 2'b10) begin
            $display("FAIL sw_strobe_wins: got %b required 10", {busy, timeout});
            n_fail++;
        end
        send_byte(8'h00); send_byte(8'h81);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h92);
        finish_read();
        n_checks++;
        if ({data_valid, crc_err, timeout, temp_raw, rh_raw} !== {3'b100, 16'h0000, 16'hBEEF}) begin
            $display("FAIL sw_result: got dv=%b crc_err=%b to=%b temp=%h rh=%h required 1 0 0 0000 beef",
                     data_valid, crc_err, timeout, temp_raw, rh_raw);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_crc();
        test_timeout();
        test_start_held();
        test_async_reset();
        test_strobe_vs_watchdog();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
